// File: rtl/ram_pkg.sv
// Shared definitions for the ram data memory: word width, channel state
// encoding and the address range check used by both the wrapper and the
// embedded array.
package ram_pkg;

  localparam int WORD_W = 32;

  // Each channel is either ready for a new request or waiting out its latency.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } chan_state_t;

  // True when a word address falls outside the populated memory.
  function automatic logic out_of_range(input logic [WORD_W-1:0] addr,
                                        input int depth);
    return (addr >= WORD_W'(depth));
  endfunction

endpackage

// File: rtl/emb_ram.sv
// Single-cycle embedded word array. Writes land on the edge where write=1;
// reads are registered on the edge where read=1. Out-of-range accesses
// leave the array alone, read back zero and raise a one-cycle exc pulse.
module emb_ram
  import ram_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] r_addr,
  input  logic [WORD_W-1:0] w_addr,
  output logic [WORD_W-1:0] r_line,
  input  logic [WORD_W-1:0] w_line,
  input  logic              read,
  input  logic              write,
  output logic              exc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              r_oor;
  logic              w_oor;

  assign r_oor = out_of_range(r_addr, DEPTH);
  assign w_oor = out_of_range(w_addr, DEPTH);

  // Array write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (write && !w_oor) begin
      mem[w_addr[AW-1:0]] <= w_line;
    end
  end

  // Registered read port; old data is returned on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (read) begin
      if (r_oor) begin
        r_line <= '0;
      end else begin
        r_line <= mem[r_addr[AW-1:0]];
      end
    end
  end

  // Range error of whatever ports were strobed on the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc <= 1'b0;
    end else begin
      exc <= (read && r_oor) || (write && w_oor);
    end
  end

endmodule

// File: rtl/ram.sv
// Slow external data RAM model: independent read and write channels, each
// accepting one access and completing it LATENCY edges later with a
// ready/busy handshake. The actual storage is an emb_ram that is strobed
// exactly on the completion edge, so read data and write commit appear
// together with ready returning high.
module ram
  import ram_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] r_addr,
  input  logic [WORD_W-1:0] w_addr,
  output logic [WORD_W-1:0] r_line,
  input  logic [WORD_W-1:0] w_line,
  input  logic              read,
  input  logic              write,
  output logic              wrdy,
  output logic              rrdy,
  output logic              exc
);

  localparam int             CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);

  chan_state_t       r_state_reg;
  chan_state_t       w_state_reg;
  logic [CW-1:0]     r_cnt_reg;
  logic [CW-1:0]     w_cnt_reg;
  logic [WORD_W-1:0] r_addr_reg;
  logic [WORD_W-1:0] w_addr_reg;
  logic [WORD_W-1:0] w_data_reg;
  logic              exc_hold_reg;

  logic              r_accept;
  logic              w_accept;
  logic              r_done;
  logic              w_done;
  logic              emb_exc;

  // Accepts only happen from IDLE; completion is the edge where the
  // counter steps from 1 to 0. Reset masks both so a pending write is
  // dropped instead of committing on the reset edge.
  assign r_accept = read  && (r_state_reg == IDLE) && !rst;
  assign w_accept = write && (w_state_reg == IDLE) && !rst;
  assign r_done   = (r_state_reg == BUSY) && (r_cnt_reg == CNT_LAST) && !rst;
  assign w_done   = (w_state_reg == BUSY) && (w_cnt_reg == CNT_LAST) && !rst;

  assign rrdy = (r_state_reg == IDLE);
  assign wrdy = (w_state_reg == IDLE);

  // Read channel: capture address on accept, count down while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= IDLE;
      r_cnt_reg   <= '0;
      r_addr_reg  <= '0;
    end else if (r_accept) begin
      r_state_reg <= BUSY;
      r_cnt_reg   <= CNT_LOAD;
      r_addr_reg  <= r_addr;
    end else if (r_state_reg == BUSY) begin
      r_cnt_reg <= r_cnt_reg - CW'(1);
      if (r_cnt_reg == CNT_LAST) begin
        r_state_reg <= IDLE;
      end
    end
  end

  // Write channel: capture address and data on accept, count down while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= IDLE;
      w_cnt_reg   <= '0;
      w_addr_reg  <= '0;
      w_data_reg  <= '0;
    end else if (w_accept) begin
      w_state_reg <= BUSY;
      w_cnt_reg   <= CNT_LOAD;
      w_addr_reg  <= w_addr;
      w_data_reg  <= w_line;
    end else if (w_state_reg == BUSY) begin
      w_cnt_reg <= w_cnt_reg - CW'(1);
      if (w_cnt_reg == CNT_LAST) begin
        w_state_reg <= IDLE;
      end
    end
  end

  // emb_ram reports a range error only for the cycle after a completion;
  // this register keeps it visible until either channel accepts again.
  // A completion error on the same edge as an accept still shows because
  // the fresh emb_exc pulse is ORed in directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_hold_reg <= 1'b0;
    end else if (r_accept || w_accept) begin
      exc_hold_reg <= 1'b0;
    end else begin
      exc_hold_reg <= exc;
    end
  end

  assign exc = exc_hold_reg || emb_exc;

  emb_ram #(
    .DEPTH (DEPTH)
  ) u_emb_ram (
    .clk    (clk),
    .rst    (rst),
    .r_addr (r_addr_reg),
    .w_addr (w_addr_reg),
    .r_line (r_line),
    .w_line (w_data_reg),
    .read   (r_done),
    .write  (w_done),
    .exc    (emb_exc)
  );

endmodule

// File: tb/tb_ram.sv
// Directed plus randomized bench for ram. A transaction-level model (plain
// array + expected read word) predicts data, exc and ready timing.
module tb_ram;

  localparam int DEPTH = 4096;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r_addr = '0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_line = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] r_line;
  logic        wrdy;
  logic        rrdy;
  logic        exc;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rline;

  ram #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .r_addr (r_addr),
    .w_addr (w_addr),
    .r_line (r_line),
    .w_line (w_line),
    .read   (read),
    .write  (write),
    .wrdy   (wrdy),
    .rrdy   (rrdy),
    .exc    (exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on either or both channels, starting from idle. Checks
  // ready low from the accept edge, exc cleared at accept, and data,
  // exc and ready at the completion edge LAT cycles later.
  task automatic do_access(input bit dr, input bit dw, input logic [31:0] ra,
                           input logic [31:0] wa, input logic [31:0] wd,
                           input string tag);
    logic exp_exc;
    read = dr;
    write = dw;
    r_addr = ra;
    w_addr = wa;
    w_line = wd;
    exp_exc = (dr && ra >= 32'(DEPTH)) || (dw && wa >= 32'(DEPTH));
    // Read sees the array before this access's write lands.
    if (dr) begin
      if (ra < 32'(DEPTH)) model_rline = model_mem[ra];
      else model_rline = '0;
    end
    if (dw && wa < 32'(DEPTH)) model_mem[wa] = wd;
    step();
    read = 1'b0;
    write = 1'b0;
    r_addr = $urandom;
    w_addr = $urandom;
    w_line = $urandom;
    check($sformatf("%s.rrdy_accept", tag), 32'(rrdy), 32'(!dr));
    check($sformatf("%s.wrdy_accept", tag), 32'(wrdy), 32'(!dw));
    check($sformatf("%s.exc_accept", tag), 32'(exc), 32'(0));
    for (int k = 1; k < LAT; k++) begin
      step();
      check($sformatf("%s.rrdy_busy%0d", tag, k), 32'(rrdy), 32'(!dr));
      check($sformatf("%s.wrdy_busy%0d", tag, k), 32'(wrdy), 32'(!dw));
    end
    step();
    check($sformatf("%s.rrdy_done", tag), 32'(rrdy), 32'(1));
    check($sformatf("%s.wrdy_done", tag), 32'(wrdy), 32'(1));
    check($sformatf("%s.r_line", tag), r_line, model_rline);
    check($sformatf("%s.exc_done", tag), 32'(exc), 32'(exp_exc));
    $display("txn %s rd=%0d wr=%0d ra=%h wa=%h wd=%h r_line=%h exc=%0d",
             tag, dr, dw, ra, wa, wd, r_line, exc);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          dr;
    bit          dw;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rline = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    check("reset.wrdy", 32'(wrdy), 32'(1));
    check("reset.rrdy", 32'(rrdy), 32'(1));
    check("reset.r_line", r_line, 32'h0);
    check("reset.exc", 32'(exc), 32'(0));
    rst = 1'b0;
    step();
    check("idle.wrdy", 32'(wrdy), 32'(1));
    check("idle.rrdy", 32'(rrdy), 32'(1));

    // Basic read of unwritten word, write then read back.
    do_access(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, "rd0");
    do_access(1'b0, 1'b1, 32'd0, 32'd5, 32'hDEADBEEF, "wr5");
    do_access(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, "rd5");

    // Concurrent write i<<1 -> i+1 while reading i.
    for (int i = 0; i < 1024; i++) begin
      do_access(1'b1, 1'b1, 32'(i), 32'(i + 1), 32'(i) << 1, $sformatf("loop%0d", i));
    end

    // Read held high: re-accepted on the edge after each completion.
    read = 1'b1;
    r_addr = 32'd3;
    model_rline = model_mem[3];
    for (int c = 0; c <= 2 * LAT + 1; c++) begin
      step();
      check($sformatf("held.rrdy%0d", c), 32'(rrdy), 32'((c % (LAT + 1)) == LAT));
    end
    read = 1'b0;
    check("held.r_line", r_line, model_rline);
    $display("txn held_read addr=3 r_line=%h", r_line);

    // Out-of-range read, then in-range access clears exc at accept.
    do_access(1'b1, 1'b0, 32'(DEPTH), 32'd0, 32'd0, "rd_oor");
    do_access(1'b1, 1'b0, 32'd10, 32'd0, 32'd0, "rd10");

    // Out-of-range write must not disturb the array.
    do_access(1'b0, 1'b1, 32'd0, 32'(DEPTH + 7), 32'hCAFEF00D, "wr_oor");
    do_access(1'b1, 1'b0, 32'd7, 32'd0, 32'd0, "rb7");
    do_access(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, "rb0");
    do_access(1'b1, 1'b0, 32'(DEPTH - 1), 32'd0, 32'd0, "rb_last");

    // Reset two cycles into a write drops the write.
    write = 1'b1;
    w_addr = 32'd9;
    w_line = 32'h12345678;
    step();
    write = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst.wrdy", 32'(wrdy), 32'(1));
    check("midrst.rrdy", 32'(rrdy), 32'(1));
    check("midrst.r_line", r_line, 32'h0);
    check("midrst.exc", 32'(exc), 32'(0));
    rst = 1'b0;
    model_rline = '0;
    step();
    $display("txn midrst_write addr=9 wrdy=%0d", wrdy);
    do_access(1'b1, 1'b0, 32'd9, 32'd0, 32'd0, "rb9");

    // Randomized mix, small address window for collisions plus OOR cases.
    for (int n = 0; n < 300; n++) begin
      dr = 1'($urandom);
      dw = 1'($urandom);
      if (!dr && !dw) dr = 1'b1;
      ra = 32'($urandom_range(0, 15));
      wa = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ra = 32'(DEPTH) + 32'($urandom_range(0, 50));
      if ($urandom_range(0, 9) == 0) wa = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      wd = $urandom;
      do_access(dr, dw, ra, wa, wd, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
